// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES controller slice.
//   key_len_t        : encoding of the runtime key-length selector
//   aes_ctrl_state_t : controller state encoding
//   nr_of()          : number of cipher rounds for a key length
//   NR_MAX, NB       : largest round count and block width in 32-bit words
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int NR_MAX = 14;
  localparam int NB     = 4;

  typedef enum logic [1:0] {
    KL128 = 2'd0,
    KL192 = 2'd1,
    KL256 = 2'd2,
    KLBAD = 2'd3
  } key_len_t;

  typedef enum logic [2:0] {
    IDLE,
    KEY_INIT,
    KEY_EXP,
    ARK,
    ROUND,
    LAST,
    OUT
  } aes_ctrl_state_t;

  // The illegal code falls back to the AES-128 count; the controller never
  // latches it because an illegal key is rejected before nr is updated.
  function automatic logic [3:0] nr_of(key_len_t kl);
    case (kl)
      KL192:   nr_of = 4'd12;
      KL256:   nr_of = 4'd14;
      default: nr_of = 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_timer.sv
// ---------------------------------------------------------------------------
// aes_round_timer
// Paces the round datapath: a ROUND_LAT-cycle sub-counter plus the round
// counter r.
//   clk, reset   : clock, asynchronous active-low reset
//   start        : load r=1 and restart the sub-counter (issued during ARK)
//   enable       : advance while the datapath is executing a round
//   nr           : round count of the loaded key schedule
//   r            : current round number (1..nr)
//   round_tick   : final cycle of the current round pass
//   last_round   : r is the last full round (r == nr-1)
// ---------------------------------------------------------------------------
module aes_round_timer #(
  parameter int ROUND_LAT = 1,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             enable,
  input  logic [IDX_W-1:0] nr,
  output logic [IDX_W-1:0] r,
  output logic             round_tick,
  output logic             last_round
);

  // ROUND_LAT is at most 4, so two bits always cover the sub-counter.
  localparam int              SUB_W    = 2;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(ROUND_LAT - 1);

  logic [SUB_W-1:0] sub;

  // Sub-counter wraps on the final cycle of each pass and bumps the round
  // number, so r is stable for every cycle of a pass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub <= '0;
      r   <= '0;
    end else if (start) begin
      sub <= '0;
      r   <= IDX_W'(1);
    end else if (enable) begin
      if (round_tick) begin
        sub <= '0;
        r   <= r + IDX_W'(1);
      end else begin
        sub <= sub + SUB_W'(1);
      end
    end
  end

  assign round_tick = (sub == SUB_LAST);
  assign last_round = (r == nr - IDX_W'(1));

endmodule

// File: rtl/aes_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// aes_ctrl_fsm
// Iterative AES-128/192/256 control FSM: sequences key expansion into the
// round-key store and the encrypt/decrypt round passes of the datapath.
//   clk, reset            : clock, asynchronous active-low reset
//   key_len/valid/ready   : cipher-key handshake (0=128, 1=192, 2=256, 3=bad)
//   key_err               : one-cycle pulse after an illegal key_len is taken
//   key_loaded            : round-key store holds a complete schedule
//   in_valid/decrypt/ready: input-block handshake, direction sampled with it
//   out_valid/ready       : result handshake with backpressure
//   ke_load, ke_step      : key expander strobes
//   rk_we, rk_waddr       : round-key store write port
//   rk_raddr              : round-key store read index
//   ld_in, ld_round, ld_last : datapath load strobes
//   inv                   : datapath in inverse-cipher mode
//   busy                  : controller not idle
// ---------------------------------------------------------------------------
module aes_ctrl_fsm
  import aes_pkg::*;
#(
  parameter int ROUND_LAT  = 1,
  parameter int IDX_W      = 4,
  parameter int ENABLE_DEC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       key_len,
  input  logic             key_valid,
  output logic             key_ready,
  output logic             key_err,
  output logic             key_loaded,
  input  logic             in_valid,
  input  logic             in_decrypt,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ke_load,
  output logic             ke_step,
  output logic             rk_we,
  output logic [IDX_W-1:0] rk_waddr,
  output logic [IDX_W-1:0] rk_raddr,
  output logic             ld_in,
  output logic             ld_round,
  output logic             ld_last,
  output logic             inv,
  output logic             busy
);

  aes_ctrl_state_t state, state_next;

  logic [IDX_W-1:0] nr;
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] r;
  logic             inv_q;
  logic             key_loaded_q;
  logic             key_err_q;
  logic             round_tick;
  logic             last_round;
  logic             key_hs;
  logic             data_hs;
  logic             key_illegal;

  // key_ready is qualified with reset so every output is low while reset is
  // held, not just once the first clock edge arrives.
  assign key_ready   = (state == IDLE) && reset;
  assign in_ready    = ((state == IDLE) || ((state == OUT) && out_ready))
                       && key_loaded_q && !key_valid;
  assign key_hs      = key_valid && key_ready;
  assign data_hs     = in_valid && in_ready;
  assign key_illegal = (key_len_t'(key_len) == KLBAD);

  aes_round_timer #(
    .ROUND_LAT (ROUND_LAT),
    .IDX_W     (IDX_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .start      (state == ARK),
    .enable     ((state == ROUND) || (state == LAST)),
    .nr         (nr),
    .r          (r),
    .round_tick (round_tick),
    .last_round (last_round)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Key-schedule bookkeeping and per-block direction. nr only changes on a
  // legal key handshake, so key_len wiggles at any other time are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nr           <= IDX_W'(10);
      k            <= '0;
      inv_q        <= 1'b0;
      key_loaded_q <= 1'b0;
      key_err_q    <= 1'b0;
    end else begin
      key_err_q <= key_hs && key_illegal;
      if (key_hs) begin
        key_loaded_q <= 1'b0;
        if (!key_illegal) begin
          nr <= IDX_W'(nr_of(key_len_t'(key_len)));
        end
      end
      if (state == KEY_INIT) begin
        k <= IDX_W'(1);
      end else if (state == KEY_EXP) begin
        if (k == nr) begin
          k            <= '0;
          key_loaded_q <= 1'b1;
        end else begin
          k <= k + IDX_W'(1);
        end
      end
      if (data_hs) begin
        inv_q <= in_decrypt && (ENABLE_DEC != 0);
      end
    end
  end

  // Next-state logic. A pending key blocks in_ready, so the key handshake
  // always wins over data without an explicit priority check here.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (key_hs) begin
          if (!key_illegal) state_next = KEY_INIT;
        end else if (data_hs) begin
          state_next = ARK;
        end
      end
      KEY_INIT: state_next = KEY_EXP;
      KEY_EXP:  if (k == nr) state_next = IDLE;
      ARK:      state_next = (nr == IDX_W'(1)) ? LAST : ROUND;
      ROUND:    if (round_tick && last_round) state_next = LAST;
      LAST:     if (round_tick) state_next = OUT;
      OUT: begin
        if (out_ready) state_next = data_hs ? ARK : IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  // Moore outputs. Decryption walks the key schedule backwards.
  always_comb begin
    ke_load   = 1'b0;
    ke_step   = 1'b0;
    rk_we     = 1'b0;
    rk_waddr  = '0;
    rk_raddr  = '0;
    ld_in     = 1'b0;
    ld_round  = 1'b0;
    ld_last   = 1'b0;
    out_valid = 1'b0;
    case (state)
      KEY_INIT: begin
        ke_load = 1'b1;
        rk_we   = 1'b1;
      end
      KEY_EXP: begin
        ke_step  = 1'b1;
        rk_we    = 1'b1;
        rk_waddr = k;
      end
      ARK: begin
        ld_in    = 1'b1;
        rk_raddr = inv_q ? nr : '0;
      end
      ROUND: begin
        rk_raddr = inv_q ? (nr - r) : r;
        ld_round = round_tick;
      end
      LAST: begin
        rk_raddr = inv_q ? '0 : nr;
        ld_last  = round_tick;
      end
      OUT:      out_valid = 1'b1;
      default: ;
    endcase
  end

  assign key_err    = key_err_q;
  assign key_loaded = key_loaded_q;
  assign inv        = inv_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_aes_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_aes_ctrl_fsm
// Drives two controllers (ROUND_LAT=1 and ROUND_LAT=3) and compares every
// strobe against a cycle trace rebuilt from AES round arithmetic.
// ---------------------------------------------------------------------------
module tb_aes_ctrl_fsm;

  logic clk = 1'b0;
  logic reset;

  logic [1:0] key_len    [2];
  logic       key_valid  [2];
  logic       in_valid   [2];
  logic       in_decrypt [2];
  logic       out_ready  [2];
  logic       key_ready  [2];
  logic       key_err    [2];
  logic       key_loaded [2];
  logic       in_ready   [2];
  logic       out_valid  [2];
  logic       ke_load    [2];
  logic       ke_step    [2];
  logic       rk_we      [2];
  logic [3:0] rk_waddr   [2];
  logic [3:0] rk_raddr   [2];
  logic       ld_in      [2];
  logic       ld_round   [2];
  logic       ld_last    [2];
  logic       inv        [2];
  logic       busy       [2];

  int vectors     = 0;
  int miscompares = 0;
  int model_nr [2];

  always #5 clk = ~clk;

  aes_ctrl_fsm #(.ROUND_LAT(1), .IDX_W(4), .ENABLE_DEC(1)) dut0 (
    .clk(clk), .reset(reset), .key_len(key_len[0]), .key_valid(key_valid[0]),
    .key_ready(key_ready[0]), .key_err(key_err[0]), .key_loaded(key_loaded[0]),
    .in_valid(in_valid[0]), .in_decrypt(in_decrypt[0]), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .ke_load(ke_load[0]),
    .ke_step(ke_step[0]), .rk_we(rk_we[0]), .rk_waddr(rk_waddr[0]),
    .rk_raddr(rk_raddr[0]), .ld_in(ld_in[0]), .ld_round(ld_round[0]),
    .ld_last(ld_last[0]), .inv(inv[0]), .busy(busy[0])
  );

  aes_ctrl_fsm #(.ROUND_LAT(3), .IDX_W(4), .ENABLE_DEC(1)) dut1 (
    .clk(clk), .reset(reset), .key_len(key_len[1]), .key_valid(key_valid[1]),
    .key_ready(key_ready[1]), .key_err(key_err[1]), .key_loaded(key_loaded[1]),
    .in_valid(in_valid[1]), .in_decrypt(in_decrypt[1]), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .ke_load(ke_load[1]),
    .ke_step(ke_step[1]), .rk_we(rk_we[1]), .rk_waddr(rk_waddr[1]),
    .rk_raddr(rk_raddr[1]), .ld_in(ld_in[1]), .ld_round(ld_round[1]),
    .ld_last(ld_last[1]), .inv(inv[1]), .busy(busy[1])
  );

  function automatic int latOf(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // One comparison point: counts it, and reports tag/observed/expected on a miss.
  task automatic checkOutput(int d, string tag, logic [31:0] observed, logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s dut%0d observed=%0h expected=%0h", tag, d, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(int d, bit kv, logic [1:0] kl, bit iv, bit dec, bit ordy);
    key_valid[d]  = kv;
    key_len[d]    = kl;
    in_valid[d]   = iv;
    in_decrypt[d] = dec;
    out_ready[d]  = ordy;
    #1;
  endtask

  task automatic checkQuiet(int d, string tag);
    checkOutput(d, tag, {key_ready[d], key_err[d], key_loaded[d], in_ready[d],
                         out_valid[d], ke_load[d], ke_step[d], rk_we[d],
                         ld_in[d], ld_round[d], ld_last[d], inv[d], busy[d]}, 0);
    checkOutput(d, {tag, "_addr"}, {rk_waddr[d], rk_raddr[d]}, 0);
  endtask

  // Key handshake then nr+1 cycles of expansion; key_len is scrambled after
  // the handshake since it must no longer matter.
  task automatic loadKey(int d, int kl, bit with_data);
    int nr;
    nr = 10 + 2 * kl;
    applyStimulus(d, 1'b1, 2'(kl), with_data, 1'b0, 1'b0);
    checkOutput(d, "key_ready", key_ready[d], 1);
    if (with_data) checkOutput(d, "prio_in_ready", in_ready[d], 0);
    step();
    applyStimulus(d, 1'b0, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
    for (int c = 0; c <= nr; c++) begin
      checkOutput(d, "ke_load", ke_load[d], (c == 0));
      checkOutput(d, "ke_step", ke_step[d], (c != 0));
      checkOutput(d, "rk_we", rk_we[d], 1);
      checkOutput(d, "rk_waddr", rk_waddr[d], c);
      checkOutput(d, "kx_loaded", key_loaded[d], 0);
      checkOutput(d, "kx_strobes", {ld_in[d], ld_round[d], ld_last[d], out_valid[d]}, 0);
      step();
    end
    checkOutput(d, "key_loaded", key_loaded[d], 1);
    checkOutput(d, "key_idle", {busy[d], rk_we[d], ke_step[d]}, 0);
    model_nr[d] = nr;
  endtask

  task automatic accept(int d, bit dec);
    applyStimulus(d, 1'b0, 2'($urandom_range(0, 3)), 1'b1, dec, 1'b0);
    checkOutput(d, "acc_in_ready", in_ready[d], 1);
    step();
    applyStimulus(d, 1'b0, 2'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // Expected trace: ARK, then rounds 1..nr (round nr is the final round),
  // each ROUND_LAT cycles long with its load strobe on the last cycle.
  task automatic blockBody(int d, bit dec);
    int nr, rl, total, p, rnd;
    bit e_in, e_rnd, e_last, fin;
    int e_addr;
    nr    = model_nr[d];
    rl    = latOf(d);
    total = 1 + nr * rl;
    for (int c = 0; c < total; c++) begin
      e_in = 0; e_rnd = 0; e_last = 0;
      if (c == 0) begin
        e_in   = 1;
        e_addr = dec ? nr : 0;
      end else begin
        p   = c - 1;
        rnd = p / rl + 1;
        fin = ((p % rl) == rl - 1);
        if (rnd < nr) begin
          e_rnd  = fin;
          e_addr = dec ? nr - rnd : rnd;
        end else begin
          e_last = fin;
          e_addr = dec ? 0 : nr;
        end
      end
      checkOutput(d, "ld_in", ld_in[d], e_in);
      checkOutput(d, "ld_round", ld_round[d], e_rnd);
      checkOutput(d, "ld_last", ld_last[d], e_last);
      checkOutput(d, "rk_raddr", rk_raddr[d], e_addr);
      checkOutput(d, "inv", inv[d], dec);
      checkOutput(d, "run_flags", {out_valid[d], in_ready[d], busy[d]}, 3'b001);
      step();
    end
    checkOutput(d, "out_valid", out_valid[d], 1);
    checkOutput(d, "out_inv", inv[d], dec);
  endtask

  task automatic stallOut(int d, int n, bit dec);
    for (int i = 0; i < n; i++) begin
      applyStimulus(d, 1'b0, 2'b00, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      checkOutput(d, "stall_valid", out_valid[d], 1);
      checkOutput(d, "stall_strobes", {ld_in[d], ld_round[d], ld_last[d], in_ready[d]}, 0);
      checkOutput(d, "stall_inv", inv[d], dec);
      step();
    end
  endtask

  task automatic finishOut(int d, bit chain, bit dec2);
    applyStimulus(d, 1'b0, 2'b00, chain, dec2, 1'b1);
    checkOutput(d, "out_in_ready", in_ready[d], 1);
    step();
    applyStimulus(d, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    if (chain) begin
      blockBody(d, dec2);
    end else begin
      checkOutput(d, "back_idle", {out_valid[d], busy[d], key_ready[d]}, 3'b001);
    end
  endtask

  initial begin
    bit dec, dec2, chain;
    int kl;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) applyStimulus(d, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    #2;
    checkQuiet(0, "por");
    checkQuiet(1, "por");
    step();
    reset = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin
      checkOutput(d, "post_rst", {key_ready[d], key_loaded[d], in_ready[d], busy[d]}, 4'b1000);
    end

    $display("[TB] AES-128 encrypt, ROUND_LAT=1");
    loadKey(0, 0, 1'b0);
    accept(0, 1'b0);
    blockBody(0, 1'b0);
    stallOut(0, 5, 1'b0);
    finishOut(0, 1'b1, 1'b1);
    finishOut(0, 1'b0, 1'b0);

    $display("[TB] AES-256 decrypt, ROUND_LAT=3");
    loadKey(1, 2, 1'b0);
    accept(1, 1'b1);
    blockBody(1, 1'b1);
    stallOut(1, 5, 1'b1);
    finishOut(1, 1'b1, 1'b0);
    stallOut(1, 2, 1'b0);
    finishOut(1, 1'b0, 1'b0);

    $display("[TB] key priority over data");
    loadKey(0, 1, 1'b1);

    $display("[TB] illegal key length");
    applyStimulus(0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    checkOutput(0, "bad_key_ready", key_ready[0], 1);
    step();
    applyStimulus(0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    checkOutput(0, "key_err", key_err[0], 1);
    checkOutput(0, "bad_state", {key_loaded[0], busy[0], in_ready[0]}, 0);
    step();
    checkOutput(0, "key_err_pulse", key_err[0], 0);
    checkOutput(0, "bad_stall", {busy[0], ld_in[0], in_ready[0]}, 0);
    applyStimulus(0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] randomized blocks");
    for (int it = 0; it < 3; it++) begin
      for (int d = 0; d < 2; d++) begin
        kl    = $urandom_range(0, 2);
        dec   = 1'($urandom_range(0, 1));
        dec2  = 1'($urandom_range(0, 1));
        chain = 1'($urandom_range(0, 1));
        loadKey(d, kl, 1'b0);
        accept(d, dec);
        blockBody(d, dec);
        stallOut(d, $urandom_range(0, 4), dec);
        finishOut(d, chain, dec2);
        if (chain) finishOut(d, 1'b0, 1'b0);
      end
    end

    $display("[TB] reset during key expansion");
    applyStimulus(1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    checkOutput(1, "mid_exp_k", {ke_step[1], rk_waddr[1]}, {1'b1, 4'd4});
    reset = 1'b0;
    #1;
    checkQuiet(1, "rst_exp");
    checkQuiet(0, "rst_exp");
    step();
    reset = 1'b1;
    step();
    checkOutput(1, "rel_exp", {key_loaded[1], key_ready[1], busy[1]}, 3'b010);

    $display("[TB] reset during round 5");
    kl  = $urandom_range(0, 2);
    dec = 1'($urandom_range(0, 1));
    loadKey(1, kl, 1'b0);
    accept(1, dec);
    for (int i = 0; i < 1 + 4 * latOf(1) + 1; i++) step();
    checkOutput(1, "r5_raddr", rk_raddr[1], dec ? model_nr[1] - 5 : 5);
    reset = 1'b0;
    #1;
    checkQuiet(1, "rst_round");
    step();
    reset = 1'b1;
    step();
    checkOutput(1, "rel_round", {key_loaded[1], key_ready[1], busy[1], out_valid[1]}, 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_ctrl_fsm.md
Name: aes_ctrl_fsm

Overview:
- Next-generation iterative AES control FSM. Sequences key expansion and encrypt/decrypt rounds for AES-128/192/256, selected at runtime.
- Drives the round-key store indices and round-datapath load strobes.
- Uses valid/ready handshakes on key, input block and output block, with output backpressure.
- Supports a multi-cycle round datapath via a parameter.

Parameters:
- ROUND_LAT, 1, cycles per round datapath pass (1..4); the load strobe fires on the last cycle.
- IDX_W, 4, width of round-key index ports (must hold 14).
- ENABLE_DEC, 1, 0 = decrypt hardware absent: in_decrypt ignored and inv held 0.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- key_len  in  2  0=AES-128 (Nr=10), 1=AES-192 (Nr=12), 2=AES-256 (Nr=14), 3=illegal
- key_valid  in  1  new cipher key present on datapath
- key_ready  out  1  FSM can accept a key
- key_err  out  1  one-cycle pulse: illegal key_len accepted
- key_loaded  out  1  round-key store holds a valid schedule
- in_valid  in  1  input block present
- in_decrypt  in  1  1=decrypt block, sampled on input handshake
- in_ready  out  1  FSM can accept a block
- out_valid  out  1  result block valid
- out_ready  in  1  consumer accepts result
- ke_load  out  1  key expander loads cipher key
- ke_step  out  1  key expander produces next round key
- rk_we  out  1  round-key store write enable
- rk_waddr  out  IDX_W  round-key write index
- rk_raddr  out  IDX_W  round-key read index
- ld_in  out  1  state reg <= input XOR rk[rk_raddr]
- ld_round  out  1  state reg <= full round result
- ld_last  out  1  output reg <= final round result (no MixColumns)
- inv  out  1  datapath in inverse-cipher mode
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, key_loaded=0, nr=10, counters=0, every output 0. Effective immediately, including mid-round or mid-expansion; any partial result is discarded.
- States: IDLE, KEY_INIT, KEY_EXP, ARK, ROUND, LAST, OUT.
- key_ready = (state==IDLE).
- in_ready = (IDLE or (OUT and out_ready)) and key_loaded and !key_valid. A pending key has priority over data.
- IDLE, key handshake, legal key_len:
  - latch nr from key_len; clear key_loaded; go to KEY_INIT.
- IDLE, key handshake, key_len=3:
  - key_err=1 for one cycle; key_loaded cleared; stay IDLE.
- KEY_INIT (1 cycle): ke_load=1, rk_we=1, rk_waddr=0; go to KEY_EXP with k=1.
- KEY_EXP (nr cycles): ke_step=1, rk_we=1, rk_waddr=k, k++. After k==nr, go to IDLE and set key_loaded=1.
  - Expansion occupies exactly nr+1 cycles.
- Data handshake: latch inv = in_decrypt & ENABLE_DEC; go to ARK.
- ARK (1 cycle): ld_in=1, rk_raddr = inv ? nr : 0; r=1; go to ROUND (or LAST if nr==1, unreachable).
- ROUND, for r = 1..nr-1:
  - each round lasts ROUND_LAT cycles;
  - rk_raddr = inv ? nr-r : r, stable for all ROUND_LAT cycles;
  - ld_round=1 only on the final cycle, then r++;
  - after r==nr-1 completes, go to LAST.
- LAST (ROUND_LAT cycles): rk_raddr = inv ? 0 : nr; ld_last on final cycle; go to OUT.
- OUT: out_valid=1, held with stable data until out_ready.
  - On out_ready: next block if the input handshake occurs in the same cycle (back-to-back → ARK), else IDLE.
- Latency: out_valid rises 1+nr*ROUND_LAT edges after the accepting edge. AES-128, ROUND_LAT=1: 11 edges.
- key_len changes outside the key handshake are ignored.
- inv is constant for a block.

Decomposition:
- Shared package aes_pkg:
  - key_len_t enum (KL128, KL192, KL256, KLBAD);
  - nr_of(key_len_t) function;
  - state typedef aes_ctrl_state_t;
  - constants NR_MAX=14 and NB=4.
- One sub-module, aes_round_timer: ROUND_LAT-cycle sub-counter plus round counter r with terminal flags round_tick and last_round. The FSM instantiates it for both the ROUND and LAST phases.

Test Plan:
- AES-128 key load (key_len=0): ke_load in 1 cycle, then ke_step 10 cycles with rk_waddr 1..10; key_loaded=1 on edge 11; no other strobes.
- AES-128 encrypt, ROUND_LAT=1:
  - ld_in with raddr 0;
  - ld_round for raddr 1..9;
  - ld_last with raddr 10;
  - out_valid 11 edges after handshake;
  - with FIPS-197 C.1 vectors in the datapath, result 69c4e0d86a7b0430d8cdb78070b4c55a.
- AES-256 decrypt, ROUND_LAT=3: raddr sequence 14,13..1,0, each round raddr held 3 cycles; out_valid 43 edges after handshake; inv=1 throughout.
- Backpressure and back-to-back:
  - out_ready=0 for 5 cycles: out_valid and result stable;
  - then out_ready=1 with in_valid=1: next ARK in the following cycle, no IDLE cycle.
- Priority and illegal key:
  - key_valid and in_valid together in IDLE: key taken, in_ready=0;
  - key_len=3: key_err pulse, key_loaded=0, later in_valid stalls (in_ready=0).
- Reset asserted mid-round (r=5) and mid-expansion (k=4): all outputs 0 immediately; after release, key_loaded=0 and key_ready=1.
